// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the unified L2 line port between the I-L1 (read-only)
// and the D-L1 (read/write-back). One line transaction is outstanding at a
// time; the winning request is captured at grant so the L2 sees a stable
// address/data bus, and the response is routed back to the owner only.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  // I-L1 side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-L1 side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // L2 side
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic              d_req;
  logic              grant_valid;
  logic              grant_owner;

  // State register; reset aborts any in-flight L2 transaction
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: requests are only looked at in IDLE, so a level still held
  // during DONE cannot start a second transaction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_read || d_req) state_d = S_SERVE;
      S_SERVE: if (l2_resp)         state_d = S_DONE;
      S_DONE:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Grant decision: single requester wins outright, a tie goes to the side
  // that did not win last time
  always_comb begin
    d_req       = d_read | d_write;
    grant_valid = (state_q == S_IDLE) && (i_read || d_req);
    if (i_read && d_req) begin
      grant_owner = ~last_grant_q;
    end else begin
      grant_owner = d_req ? OWN_D : OWN_I;
    end
  end

  // Transaction latches: captured at grant (read+write together is a
  // write-back), read data captured on the L2 completion
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    if (grant_valid) begin
      owner_d      = grant_owner;
      last_grant_d = grant_owner;
      if (grant_owner == OWN_D) begin
        op_d    = d_write ? OP_WR : OP_RD;
        addr_d  = d_address;
        wdata_d = d_wdata;
      end else begin
        op_d    = OP_RD;
        addr_d  = i_address;
      end
    end
    if ((state_q == S_SERVE) && l2_resp) begin
      rdata_d = l2_rdata;
    end
  end

  // Latch registers; last_grant resets to D so I wins the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      op_q         <= OP_RD;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    l2_read    = (state_q == S_SERVE) && (op_q == OP_RD);
    l2_write   = (state_q == S_SERVE) && (op_q == OP_WR);
    l2_address = addr_q;
    l2_wdata   = wdata_q;
    i_resp     = (state_q == S_DONE) && (owner_q == OWN_I);
    d_resp     = (state_q == S_DONE) && (owner_q == OWN_D);
    i_rdata    = rdata_q;
    d_rdata    = rdata_q;
    busy       = (state_q != S_IDLE);
  end

endmodule
